// File: rtl/mem_trace_pkg.sv
// Shared trace record format and player state encoding for the trace player and logger harness.
package mem_trace_pkg;

    localparam int unsigned TRACE_DATA_W    = 64;
    localparam int unsigned TRACE_SOURCE_W  = 32;
    localparam int unsigned TRACE_LOGSIZE_W = 32;

    typedef struct packed {
        logic [TRACE_DATA_W-1:0]    cycle;
        logic [TRACE_SOURCE_W-1:0]  source;
        logic [TRACE_DATA_W-1:0]    address;
        logic                       is_store;
        logic [TRACE_LOGSIZE_W-1:0] size;
        logic [TRACE_DATA_W-1:0]    data;
    } trace_rec_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } player_state_e;

    function automatic logic stamp_due(input logic [TRACE_DATA_W-1:0] stamp,
                                       input logic [TRACE_DATA_W-1:0] now);
        return stamp <= now;
    endfunction

endpackage

// File: rtl/mem_trace_lane_fifo.sv
// Per-lane record FIFO for the trace player; head is read combinationally from storage.
module mem_trace_lane_fifo
    import mem_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  trace_rec_t push_rec,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic       last_one,
    output trace_rec_t head
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    trace_rec_t       mem_q [DEPTH];
    trace_rec_t       mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign last_one = (count_q == (AW+1)'(1));
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_rec;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem_trace_player.sv
// Replays a cycle-stamped memory trace onto per-lane request ports.
// Optional statistics outputs are enabled by defining MEM_TRACE_PLAYER_STATS_EN.
module mem_trace_player
    import mem_trace_pkg::*;
#(
    parameter int unsigned NUM_LANES       = 4,
    parameter int unsigned LANE_FIFO_DEPTH = 4,
    parameter int unsigned DATA_WIDTH      = TRACE_DATA_W,
    parameter int unsigned SOURCEID_WIDTH  = TRACE_SOURCE_W,
    parameter int unsigned LOGSIZE_WIDTH   = TRACE_LOGSIZE_W,
    localparam int unsigned LANE_W         = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [DATA_WIDTH-1:0]               in_cycle,
    input  logic [LANE_W-1:0]                   in_lane,
    input  logic [SOURCEID_WIDTH-1:0]           in_source,
    input  logic [DATA_WIDTH-1:0]               in_address,
    input  logic                                in_is_store,
    input  logic [LOGSIZE_WIDTH-1:0]            in_size,
    input  logic [DATA_WIDTH-1:0]               in_data,
    input  logic                                in_last,
    output logic [NUM_LANES-1:0]                req_valid,
    input  logic [NUM_LANES-1:0]                req_ready,
    output logic [NUM_LANES*SOURCEID_WIDTH-1:0] req_source,
    output logic [NUM_LANES*DATA_WIDTH-1:0]     req_address,
    output logic [NUM_LANES-1:0]                req_is_store,
    output logic [NUM_LANES*LOGSIZE_WIDTH-1:0]  req_size,
    output logic [NUM_LANES*DATA_WIDTH-1:0]     req_data,
    output logic [DATA_WIDTH-1:0]               cycle,
    output logic                                done,
    output logic                                err_order
`ifdef MEM_TRACE_PLAYER_STATS_EN
    ,
    output logic [31:0]                         stat_issued,
    output logic [31:0]                         stat_stall_cycles
`endif
);

    player_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0]   cycle_q, cycle_d;
    logic [DATA_WIDTH-1:0]   last_stamp_q, last_stamp_d;
    logic                    err_order_q, err_order_d;

    trace_rec_t              in_rec;
    trace_rec_t              head [NUM_LANES];
    logic [NUM_LANES-1:0]    lane_sel, push, pop, due;
    logic [NUM_LANES-1:0]    full, empty, last_one;
    logic                    sel_full, in_range, accepting, accept;
    logic                    blocked, all_clear;

    assign in_rec = '{cycle:    in_cycle,
                      source:   in_source,
                      address:  in_address,
                      is_store: in_is_store,
                      size:     in_size,
                      data:     in_data};

    // Decode the target lane by comparison so an out-of-range index simply selects nothing.
    always_comb begin
        lane_sel = '0;
        sel_full = 1'b0;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            if (in_lane == LANE_W'(l)) begin
                lane_sel[l] = 1'b1;
                sel_full    = full[l];
            end
        end
        in_range = |lane_sel;
    end

    assign accepting = (state_q == IDLE) || (state_q == RUN);
    assign in_ready  = reset && accepting && !sel_full;
    assign accept    = in_valid && in_ready;
    assign push      = accept ? lane_sel : '0;

    always_comb begin
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            due[l] = !empty[l] && stamp_due(head[l].cycle, cycle_q);
        end
    end

    assign req_valid = due;
    assign pop       = due & req_ready;
    assign blocked   = |(due & ~req_ready);
    // Lanes that will be empty after this cycle's pops; DRAIN exits without an idle cycle.
    assign all_clear = &(empty | (pop & last_one));

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        mem_trace_lane_fifo #(
            .DEPTH(LANE_FIFO_DEPTH)
        ) u_fifo (
            .clock    (clock),
            .reset    (reset),
            .push     (push[l]),
            .push_rec (in_rec),
            .pop      (pop[l]),
            .full     (full[l]),
            .empty    (empty[l]),
            .last_one (last_one[l]),
            .head     (head[l])
        );

        assign req_source[l*SOURCEID_WIDTH +: SOURCEID_WIDTH] = head[l].source;
        assign req_address[l*DATA_WIDTH +: DATA_WIDTH]        = head[l].address;
        assign req_is_store[l]                                = head[l].is_store;
        assign req_size[l*LOGSIZE_WIDTH +: LOGSIZE_WIDTH]     = head[l].size;
        assign req_data[l*DATA_WIDTH +: DATA_WIDTH]           = head[l].data;
    end

    always_comb begin
        state_d      = state_q;
        cycle_d      = cycle_q;
        last_stamp_d = last_stamp_q;
        err_order_d  = err_order_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = in_last ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (accept && in_last) begin
                    state_d = DRAIN;
                end
                if (!blocked && in_valid && (in_cycle > cycle_q)) begin
                    cycle_d = cycle_q + 1'b1;
                end
            end
            DRAIN: begin
                if (all_clear) begin
                    state_d = DONE;
                end
                if (!blocked) begin
                    cycle_d = cycle_q + 1'b1;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            if (!in_range) begin
                err_order_d = 1'b1;
            end else begin
                if (in_cycle < last_stamp_q) begin
                    err_order_d = 1'b1;
                end
                last_stamp_d = in_cycle;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cycle_q      <= '0;
            last_stamp_q <= '0;
            err_order_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cycle_q      <= cycle_d;
            last_stamp_q <= last_stamp_d;
            err_order_q  <= err_order_d;
        end
    end

    assign cycle     = cycle_q;
    assign done      = (state_q == DONE);
    assign err_order = err_order_q;

`ifdef MEM_TRACE_PLAYER_STATS_EN
    logic [31:0] stat_issued_q, stat_issued_d;
    logic [31:0] stat_stall_q, stat_stall_d;
    logic [32:0] issued_sum;

    always_comb begin
        issued_sum    = {1'b0, stat_issued_q} + 33'($countones(pop));
        stat_issued_d = issued_sum[32] ? '1 : issued_sum[31:0];
        stat_stall_d  = stat_stall_q;
        if (blocked && ((state_q == RUN) || (state_q == DRAIN)) && (stat_stall_q != '1)) begin
            stat_stall_d = stat_stall_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_issued_q <= stat_issued_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign stat_issued       = stat_issued_q;
    assign stat_stall_cycles = stat_stall_q;
`endif

endmodule

// File: tb/tb_mem_trace_player.sv
// Randomized self-checking bench for mem_trace_player against a queue-based replay model.
// Statistics checks are compiled in when MEM_TRACE_PLAYER_STATS_EN is defined.
module tb_mem_trace_player;

    localparam int NL    = 4;
    localparam int DEPTH = 4;
    localparam int DW    = 64;
    localparam int SW    = 32;
    localparam int LW    = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW-1:0]     in_cycle = '0;
    logic [1:0]        in_lane = '0;
    logic [SW-1:0]     in_source = '0;
    logic [DW-1:0]     in_address = '0;
    logic              in_is_store = 1'b0;
    logic [LW-1:0]     in_size = '0;
    logic [DW-1:0]     in_data = '0;
    logic              in_last = 1'b0;
    logic [NL-1:0]     req_valid;
    logic [NL-1:0]     req_ready = '0;
    logic [NL*SW-1:0]  req_source;
    logic [NL*DW-1:0]  req_address;
    logic [NL-1:0]     req_is_store;
    logic [NL*LW-1:0]  req_size;
    logic [NL*DW-1:0]  req_data;
    logic [DW-1:0]     cycle;
    logic              done;
    logic              err_order;
`ifdef MEM_TRACE_PLAYER_STATS_EN
    logic [31:0]       stat_issued;
    logic [31:0]       stat_stall_cycles;
`endif

    always #5 clock = ~clock;

    mem_trace_player #(
        .NUM_LANES       (NL),
        .LANE_FIFO_DEPTH (DEPTH),
        .DATA_WIDTH      (DW),
        .SOURCEID_WIDTH  (SW),
        .LOGSIZE_WIDTH   (LW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_cycle     (in_cycle),
        .in_lane      (in_lane),
        .in_source    (in_source),
        .in_address   (in_address),
        .in_is_store  (in_is_store),
        .in_size      (in_size),
        .in_data      (in_data),
        .in_last      (in_last),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_source   (req_source),
        .req_address  (req_address),
        .req_is_store (req_is_store),
        .req_size     (req_size),
        .req_data     (req_data),
        .cycle        (cycle),
        .done         (done),
        .err_order    (err_order)
`ifdef MEM_TRACE_PLAYER_STATS_EN
        ,
        .stat_issued       (stat_issued),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    typedef struct packed {
        logic [DW-1:0] cyc;
        logic [SW-1:0] src;
        logic [DW-1:0] addr;
        logic          st;
        logic [LW-1:0] size;
        logic [DW-1:0] data;
    } rec_t;

    int checks   = 0;
    int failures = 0;

    // Reference model: per-lane pending records, replay time and trace phase
    // (0 = not started, 1 = streaming, 2 = last record seen, 3 = finished).
    rec_t          mq [NL][$];
    logic [DW-1:0] m_cycle;
    logic [DW-1:0] m_last;
    int            m_phase;
    logic          m_err;
    bit            m_acc;
    int unsigned   m_issued;
    int unsigned   m_stall;
    bit            rand_ready = 0;

    logic [NL-1:0] obs_valid;
    logic          obs_in_ready;
    logic          obs_done;
    logic          obs_err;
    logic [DW-1:0] obs_cycle;
`ifdef MEM_TRACE_PLAYER_STATS_EN
    logic [31:0]   obs_issued;
    logic [31:0]   obs_stall;
`endif

    task automatic model_reset();
        for (int l = 0; l < NL; l++) mq[l].delete();
        m_cycle  = '0;
        m_last   = '0;
        m_phase  = 0;
        m_err    = 1'b0;
        m_acc    = 0;
        m_issued = 0;
        m_stall  = 0;
    endtask

    task automatic set_payload(input int lane, input logic [DW-1:0] stamp, input bit last);
        in_lane     = 2'(lane);
        in_cycle    = stamp;
        in_last     = last;
        in_source   = $urandom;
        in_address  = {$urandom, $urandom};
        in_is_store = 1'($urandom_range(0, 1));
        in_size     = $urandom_range(0, 6);
        in_data     = {$urandom, $urandom};
    endtask

    // One clock of scoreboarding: compare DUT outputs with the model, then advance the model.
    task automatic run_cycle();
        logic [NL-1:0] ev;
        logic          rdy_exp;
        logic          blocked;
        bit            all_empty;
        int            old;
        rec_t          er;
        #1;
        for (int l = 0; l < NL; l++)
            ev[l] = (mq[l].size() > 0) && (mq[l][0].cyc <= m_cycle);
        rdy_exp = (m_phase < 2) && (mq[in_lane].size() < DEPTH);

        obs_valid    = req_valid;
        obs_in_ready = in_ready;
        obs_done     = done;
        obs_err      = err_order;
        obs_cycle    = cycle;
`ifdef MEM_TRACE_PLAYER_STATS_EN
        obs_issued   = stat_issued;
        obs_stall    = stat_stall_cycles;
`endif

        checks++;
        if (req_valid !== ev) begin
            failures++;
            $display("FAIL req_valid got=%b exp=%b t=%0t", req_valid, ev, $time);
        end
        checks++;
        if (in_ready !== rdy_exp) begin
            failures++;
            $display("FAIL in_ready got=%b exp=%b t=%0t", in_ready, rdy_exp, $time);
        end
        checks++;
        if (cycle !== m_cycle) begin
            failures++;
            $display("FAIL cycle got=%0d exp=%0d t=%0t", cycle, m_cycle, $time);
        end
        checks++;
        if (done !== (m_phase == 3)) begin
            failures++;
            $display("FAIL done got=%b exp=%b t=%0t", done, (m_phase == 3), $time);
        end
        checks++;
        if (err_order !== m_err) begin
            failures++;
            $display("FAIL err_order got=%b exp=%b t=%0t", err_order, m_err, $time);
        end
        for (int l = 0; l < NL; l++) begin
            if (ev[l]) begin
                er = mq[l][0];
                checks++;
                if ({req_source[l*SW +: SW], req_address[l*DW +: DW], req_is_store[l],
                     req_size[l*LW +: LW], req_data[l*DW +: DW]} !==
                    {er.src, er.addr, er.st, er.size, er.data}) begin
                    failures++;
                    $display("FAIL payload lane%0d got=%h/%h/%h exp=%h/%h/%h t=%0t", l,
                             req_source[l*SW +: SW], req_address[l*DW +: DW], req_data[l*DW +: DW],
                             er.src, er.addr, er.data, $time);
                end
            end
        end
`ifdef MEM_TRACE_PLAYER_STATS_EN
        checks++;
        if (stat_issued !== m_issued) begin
            failures++;
            $display("FAIL stat_issued got=%0d exp=%0d", stat_issued, m_issued);
        end
        checks++;
        if (stat_stall_cycles !== m_stall) begin
            failures++;
            $display("FAIL stat_stall got=%0d exp=%0d", stat_stall_cycles, m_stall);
        end
`endif

        old     = m_phase;
        blocked = |(ev & ~req_ready);
        for (int l = 0; l < NL; l++) begin
            if (ev[l] && req_ready[l]) begin
                void'(mq[l].pop_front());
                m_issued++;
            end
        end
        if (blocked && (old == 1 || old == 2)) m_stall++;
        m_acc = in_valid && rdy_exp;
        if (m_acc) begin
            mq[in_lane].push_back('{cyc: in_cycle, src: in_source, addr: in_address,
                                    st: in_is_store, size: in_size, data: in_data});
            if (in_cycle < m_last) m_err = 1'b1;
            m_last = in_cycle;
            if (in_last) m_phase = 2;
            else if (old == 0) m_phase = 1;
        end
        if (old == 1 && !blocked && in_valid && (in_cycle > m_cycle)) m_cycle = m_cycle + 1;
        if (old == 2 && !blocked) m_cycle = m_cycle + 1;
        all_empty = 1;
        for (int l = 0; l < NL; l++) if (mq[l].size() != 0) all_empty = 0;
        if (old == 2 && all_empty) m_phase = 3;

        @(negedge clock);
        if (rand_ready)
            for (int l = 0; l < NL; l++) req_ready[l] = ($urandom_range(0, 9) < 7);
    endtask

    task automatic send(input int lane, input logic [DW-1:0] stamp, input bit last);
        set_payload(lane, stamp, last);
        in_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            run_cycle();
            if (m_acc) break;
        end
        checks++;
        if (!m_acc) begin
            failures++;
            $display("FAIL send_timeout lane=%0d stamp=%0d got=not_accepted exp=accepted", lane, stamp);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain_until_done(input int budget);
        in_valid = 1'b0;
        for (int k = 0; k < budget; k++) begin
            run_cycle();
            if (obs_done) break;
        end
        checks++;
        if (obs_done !== 1'b1) begin
            failures++;
            $display("FAIL drain_timeout done got=%b exp=1", obs_done);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        req_ready  = '0;
        rand_ready = 0;
        #2;
        checks++;
        if ({req_valid, in_ready, done, err_order} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0", {req_valid, in_ready, done, err_order});
        end
        checks++;
        if (cycle !== '0) begin
            failures++;
            $display("FAIL reset_cycle got=%0d exp=0", cycle);
        end
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        run_cycle();
        checks++;
        if (obs_in_ready !== 1'b1 || obs_done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset in_ready=%b done=%b exp in_ready=1 done=0", obs_in_ready, obs_done);
        end
    endtask

    task automatic test_single_record();
        bit seen = 0;
        do_reset();
        req_ready = '1;
        send(0, 5, 1);
        for (int k = 0; k < 20; k++) begin
            run_cycle();
            if (obs_valid[0]) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen || obs_cycle !== 5) begin
            failures++;
            $display("FAIL single_issue seen=%0d cycle got=%0d exp=5", seen, obs_cycle);
        end
        run_cycle();
        checks++;
        if (obs_done !== 1'b1) begin
            failures++;
            $display("FAIL single_done got=%b exp=1", obs_done);
        end
    endtask

    task automatic test_all_lanes();
        bit seen = 0;
        do_reset();
        req_ready = '1;
        for (int l = 0; l < NL; l++) send(l, 3, l == NL - 1);
        for (int k = 0; k < 20; k++) begin
            run_cycle();
            if (obs_valid != 0) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen || obs_valid !== 4'hF || obs_cycle !== 3) begin
            failures++;
            $display("FAIL all_lanes valid got=%b cycle=%0d exp valid=1111 cycle=3", obs_valid, obs_cycle);
        end
        run_cycle();
        checks++;
        if (obs_valid !== 4'h0 || obs_done !== 1'b1) begin
            failures++;
            $display("FAIL all_lanes_after valid=%b done=%b exp valid=0000 done=1", obs_valid, obs_done);
        end
`ifdef MEM_TRACE_PLAYER_STATS_EN
        checks++;
        if (obs_issued !== 32'd4) begin
            failures++;
            $display("FAIL all_lanes_issued got=%0d exp=4", obs_issued);
        end
`endif
    endtask

    task automatic test_blocked_lane();
        int  nblk = 0;
        bit  frozen = 1;
        do_reset();
        req_ready = 4'b1101;
        send(1, 2, 0);
        set_payload(0, 50, 0);
        in_valid = 1'b1;
        for (int k = 0; k < 100 && nblk < 10; k++) begin
            run_cycle();
            if (m_acc) set_payload(0, 50, 0);
            if (obs_valid[1]) begin
                nblk++;
                if (obs_cycle !== 2) frozen = 0;
            end
        end
        checks++;
        if (nblk != 10 || !frozen) begin
            failures++;
            $display("FAIL blocked_freeze blocked_cycles=%0d frozen=%0d exp 10/1", nblk, frozen);
        end
        req_ready[1] = 1'b1;
        run_cycle();
`ifdef MEM_TRACE_PLAYER_STATS_EN
        checks++;
        if (obs_stall !== 32'd10) begin
            failures++;
            $display("FAIL stall_count got=%0d exp=10", obs_stall);
        end
`endif
        in_valid = 1'b0;
        send(0, 60, 1);
        drain_until_done(400);
    endtask

    task automatic test_full_fifo();
        bit low = 1;
        do_reset();
        req_ready = 4'b1011;
        for (int i = 0; i < DEPTH; i++) send(2, 0, 0);
        set_payload(2, 0, 1);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            run_cycle();
            if (obs_in_ready !== 1'b0) low = 0;
        end
        checks++;
        if (!low) begin
            failures++;
            $display("FAIL full_backpressure in_ready got=1 exp=0");
        end
        req_ready[2] = 1'b1;
        run_cycle();
        checks++;
        if (obs_in_ready !== 1'b0 || obs_valid[2] !== 1'b1) begin
            failures++;
            $display("FAIL full_pop_cycle in_ready=%b valid2=%b exp 0/1", obs_in_ready, obs_valid[2]);
        end
        req_ready[2] = 1'b0;
        run_cycle();
        checks++;
        if (obs_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL full_recover in_ready got=%b exp=1", obs_in_ready);
        end
        in_valid  = 1'b0;
        req_ready = '1;
        drain_until_done(100);
    endtask

    task automatic test_order_error();
        bit seen = 0;
        do_reset();
        req_ready = '1;
        send(0, 7, 0);
        send(0, 4, 1);
        for (int k = 0; k < 30; k++) begin
            run_cycle();
            if (obs_valid[0]) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen || obs_cycle !== 7 || obs_err !== 1'b1) begin
            failures++;
            $display("FAIL order_first cycle=%0d err=%b exp cycle=7 err=1", obs_cycle, obs_err);
        end
        run_cycle();
        checks++;
        if (obs_valid[0] !== 1'b1 || obs_cycle !== 8) begin
            failures++;
            $display("FAIL order_second valid0=%b cycle=%0d exp 1/8", obs_valid[0], obs_cycle);
        end
        drain_until_done(20);
        checks++;
        if (obs_err !== 1'b1) begin
            failures++;
            $display("FAIL order_sticky err got=%b exp=1", obs_err);
        end
    endtask

    task automatic test_random_trace();
        logic [DW-1:0] stamp = '0;
        logic [DW-1:0] c0;
        bit            held = 1;
        do_reset();
        rand_ready = 1;
        for (int i = 0; i < 40; i++) begin
            if (i == 20) begin
                in_valid = 1'b0;
                run_cycle();
                c0 = obs_cycle;
                for (int k = 0; k < 20; k++) begin
                    run_cycle();
                    if (obs_cycle !== c0) held = 0;
                end
                checks++;
                if (!held) begin
                    failures++;
                    $display("FAIL starve_hold cycle got=%0d exp=%0d", obs_cycle, c0);
                end
            end
            stamp = stamp + 64'($urandom_range(0, 3));
            send($urandom_range(0, NL - 1), stamp, i == 39);
            if ($urandom_range(0, 3) == 0) run_cycle();
        end
        drain_until_done(2000);
        rand_ready = 0;
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        req_ready = 4'b1110;
        send(0, 0, 0);
        send(1, 5, 0);
        send(2, 9, 0);
        run_cycle();
        run_cycle();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({req_valid, in_ready, done, err_order} !== '0 || cycle !== '0) begin
            failures++;
            $display("FAIL midrun_reset got=%b cycle=%0d exp=0", {req_valid, in_ready, done, err_order}, cycle);
        end
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        run_cycle();
        checks++;
        if (obs_in_ready !== 1'b1 || obs_valid !== '0) begin
            failures++;
            $display("FAIL midrun_idle in_ready=%b valid=%b exp 1/0000", obs_in_ready, obs_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_record();
        test_all_lanes();
        test_blocked_lane();
        test_full_fifo();
        test_order_error();
        test_random_trace();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
